// File: rtl/qos_packet_scheduler.sv
// qos_packet_scheduler: packet-level QoS arbiter with round-robin tie-break onto one stream sink.
// Optional build macro QOS_AGING_EN adds per-stream starvation age counters.
`default_nettype none

module qos_packet_scheduler #(
    parameter int STREAM_COUNT = 4,
    parameter int T_DATA_WIDTH = 8,
    parameter int T_QOS_WIDTH  = 4,
    parameter int AGE_LIMIT    = 8
) (
    input  logic                                   clk,
    input  logic                                   nrst,
    input  logic [STREAM_COUNT-1:0]                s_valid_i,
    input  logic [STREAM_COUNT*T_DATA_WIDTH-1:0]   s_data_i,
    input  logic [STREAM_COUNT*T_QOS_WIDTH-1:0]    s_qos_i,
    input  logic [STREAM_COUNT-1:0]                s_last_i,
    output logic [STREAM_COUNT-1:0]                s_ready_o,
    output logic                                   m_valid_o,
    output logic [T_DATA_WIDTH-1:0]                m_data_o,
    output logic [T_QOS_WIDTH-1:0]                 m_qos_o,
    output logic [$clog2(STREAM_COUNT)-1:0]        m_id_o,
    output logic                                   m_last_o,
    input  logic                                   m_ready_i
);

    localparam int IDW = $clog2(STREAM_COUNT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [IDW-1:0]         grant;
    logic [IDW-1:0]         ptr;
    logic [IDW-1:0]         winner;
    logic [T_QOS_WIDTH:0]   best_qos;
    logic                   found;
    logic                   arbitrate;

`ifdef QOS_AGING_EN
    localparam int AW = $clog2(AGE_LIMIT + 1);
    logic [AW-1:0] age [STREAM_COUNT];
`endif

    assign arbitrate = (state == IDLE) && (|s_valid_i);

    // Scan in round-robin order from ptr+1; a strict '>' keeps the earliest tied stream.
    always_comb begin
        int                   cand;
        logic [T_QOS_WIDTH:0] eff;
        cand     = 0;
        eff      = '0;
        best_qos = '0;
        winner   = ptr;
        found    = 1'b0;
        for (int i = 0; i < STREAM_COUNT; i++) begin
            cand = int'(ptr) + 1 + i;
            if (cand >= STREAM_COUNT) begin
                cand = cand - STREAM_COUNT;
            end
            eff = {1'b0, s_qos_i[cand*T_QOS_WIDTH +: T_QOS_WIDTH]};
`ifdef QOS_AGING_EN
            if (age[cand] == AW'(AGE_LIMIT)) begin
                eff = {1'b1, {T_QOS_WIDTH{1'b0}}};
            end
`endif
            if (s_valid_i[cand] && (!found || (eff > best_qos))) begin
                found    = 1'b1;
                best_qos = eff;
                winner   = IDW'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        s_ready_o  = '0;
        m_valid_o  = 1'b0;
        m_data_o   = '0;
        m_last_o   = 1'b0;
        case (state)
            IDLE: begin
                if (|s_valid_i) begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                m_valid_o        = s_valid_i[grant];
                m_data_o         = s_data_i[grant*T_DATA_WIDTH +: T_DATA_WIDTH];
                m_last_o         = s_last_i[grant];
                s_ready_o[grant] = m_ready_i;
                if (s_valid_i[grant] && m_ready_i && s_last_i[grant]) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            grant   <= '0;
            ptr     <= '0;
            m_id_o  <= '0;
            m_qos_o <= '0;
        end else begin
            if (arbitrate) begin
                grant   <= winner;
                m_id_o  <= winner;
                m_qos_o <= s_qos_i[winner*T_QOS_WIDTH +: T_QOS_WIDTH];
            end
            if ((state == BUSY) && (next_state == IDLE)) begin
                ptr <= grant;
            end
        end
    end

`ifdef QOS_AGING_EN
    // Losers of an arbitration age by one (saturating); the winner restarts at zero.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < STREAM_COUNT; k++) begin
                age[k] <= '0;
            end
        end else if (arbitrate) begin
            for (int k = 0; k < STREAM_COUNT; k++) begin
                if (IDW'(k) == winner) begin
                    age[k] <= '0;
                end else if (s_valid_i[k] && (age[k] != AW'(AGE_LIMIT))) begin
                    age[k] <= age[k] + AW'(1);
                end
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_qos_packet_scheduler.sv
// tb_qos_packet_scheduler: table-driven cycle vectors plus directed multi-cycle sequences.
`default_nettype none

module tb_qos_packet_scheduler;

    logic        clk;
    logic        nrst;
    logic [3:0]  s_valid_i;
    logic [31:0] s_data_i;
    logic [15:0] s_qos_i;
    logic [3:0]  s_last_i;
    logic [3:0]  s_ready_o;
    logic        m_valid_o;
    logic [7:0]  m_data_o;
    logic [3:0]  m_qos_o;
    logic [1:0]  m_id_o;
    logic        m_last_o;
    logic        m_ready_i;

    int checks   = 0;
    int failures = 0;

    qos_packet_scheduler #(
        .STREAM_COUNT (4),
        .T_DATA_WIDTH (8),
        .T_QOS_WIDTH  (4),
        .AGE_LIMIT    (3)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .s_valid_i (s_valid_i),
        .s_data_i  (s_data_i),
        .s_qos_i   (s_qos_i),
        .s_last_i  (s_last_i),
        .s_ready_o (s_ready_o),
        .m_valid_o (m_valid_o),
        .m_data_o  (m_data_o),
        .m_qos_o   (m_qos_o),
        .m_id_o    (m_id_o),
        .m_last_o  (m_last_o),
        .m_ready_i (m_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  v;
        logic [15:0] q;
        logic [3:0]  l;
        logic        r;
        logic        ev;
        logic [1:0]  id;
        logic [3:0]  qos;
        logic        el;
        logic [7:0]  ed;
        logic [3:0]  sr;
    } vec_t;

    vec_t tbl [24];

    function automatic vec_t mk(logic [3:0] v, logic [15:0] q, logic [3:0] l, logic r,
                                logic ev, logic [1:0] id, logic [3:0] qos, logic el,
                                logic [7:0] ed, logic [3:0] sr);
        vec_t t;
        t.v = v; t.q = q; t.l = l; t.r = r;
        t.ev = ev; t.id = id; t.qos = qos; t.el = el; t.ed = ed; t.sr = sr;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    localparam logic [31:0] DATA_TAB = 32'hA3A2A1A0;

    initial begin
        int b;
        logic [1:0] exp_id;

        // tie RR, then QoS win, then stall/preemption attempt; data per stream is 0xA0+k
        tbl[0]  = mk(4'hF, 16'h5555, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00, 4'h0);
        tbl[1]  = mk(4'hF, 16'h5555, 4'hF, 1'b1, 1'b1, 2'd1, 4'h5, 1'b1, 8'hA1, 4'h2);
        tbl[2]  = mk(4'hF, 16'h5555, 4'hF, 1'b1, 1'b0, 2'd1, 4'h5, 1'b0, 8'h00, 4'h0);
        tbl[3]  = mk(4'hF, 16'h5555, 4'hF, 1'b1, 1'b1, 2'd2, 4'h5, 1'b1, 8'hA2, 4'h4);
        tbl[4]  = mk(4'hF, 16'h5555, 4'hF, 1'b1, 1'b0, 2'd2, 4'h5, 1'b0, 8'h00, 4'h0);
        tbl[5]  = mk(4'hF, 16'h5555, 4'hF, 1'b1, 1'b1, 2'd3, 4'h5, 1'b1, 8'hA3, 4'h8);
        tbl[6]  = mk(4'hF, 16'h5555, 4'hF, 1'b1, 1'b0, 2'd3, 4'h5, 1'b0, 8'h00, 4'h0);
        tbl[7]  = mk(4'hF, 16'h5555, 4'hF, 1'b1, 1'b1, 2'd0, 4'h5, 1'b1, 8'hA0, 4'h1);
        tbl[8]  = mk(4'hF, 16'h5555, 4'hF, 1'b1, 1'b0, 2'd0, 4'h5, 1'b0, 8'h00, 4'h0);
        tbl[9]  = mk(4'hF, 16'h5555, 4'hF, 1'b1, 1'b1, 2'd1, 4'h5, 1'b1, 8'hA1, 4'h2);
        tbl[10] = mk(4'h5, 16'h0902, 4'h0, 1'b1, 1'b0, 2'd1, 4'h5, 1'b0, 8'h00, 4'h0);
        tbl[11] = mk(4'h5, 16'h0902, 4'h0, 1'b1, 1'b1, 2'd2, 4'h9, 1'b0, 8'hA2, 4'h4);
        tbl[12] = mk(4'h5, 16'h0902, 4'h0, 1'b1, 1'b1, 2'd2, 4'h9, 1'b0, 8'hA2, 4'h4);
        tbl[13] = mk(4'h5, 16'h0902, 4'h4, 1'b1, 1'b1, 2'd2, 4'h9, 1'b1, 8'hA2, 4'h4);
        tbl[14] = mk(4'h1, 16'h0902, 4'h0, 1'b1, 1'b0, 2'd2, 4'h9, 1'b0, 8'h00, 4'h0);
        tbl[15] = mk(4'h1, 16'h0902, 4'h0, 1'b1, 1'b1, 2'd0, 4'h2, 1'b0, 8'hA0, 4'h1);
        tbl[16] = mk(4'h1, 16'h0902, 4'h1, 1'b1, 1'b1, 2'd0, 4'h2, 1'b1, 8'hA0, 4'h1);
        tbl[17] = mk(4'h0, 16'h0902, 4'h0, 1'b1, 1'b0, 2'd0, 4'h2, 1'b0, 8'h00, 4'h0);
        tbl[18] = mk(4'h0, 16'h0902, 4'h0, 1'b1, 1'b0, 2'd0, 4'h2, 1'b0, 8'h00, 4'h0);
        tbl[19] = mk(4'h2, 16'h00F0, 4'h2, 1'b0, 1'b0, 2'd0, 4'h2, 1'b0, 8'h00, 4'h0);
        tbl[20] = mk(4'h2, 16'h00F0, 4'h2, 1'b0, 1'b1, 2'd1, 4'hF, 1'b1, 8'hA1, 4'h0);
        tbl[21] = mk(4'hF, 16'hFFFF, 4'h2, 1'b0, 1'b1, 2'd1, 4'hF, 1'b1, 8'hA1, 4'h0);
        tbl[22] = mk(4'hF, 16'hFFFF, 4'h2, 1'b1, 1'b1, 2'd1, 4'hF, 1'b1, 8'hA1, 4'h2);
        tbl[23] = mk(4'h0, 16'hFFFF, 4'h0, 1'b1, 1'b0, 2'd1, 4'hF, 1'b0, 8'h00, 4'h0);

        // Reset held with every stream requesting
        nrst      = 1'b0;
        s_valid_i = 4'hF;
        s_qos_i   = 16'h5555;
        s_last_i  = 4'hF;
        s_data_i  = DATA_TAB;
        m_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst s_ready", 32'(s_ready_o), 32'h0);
        chk("rst m_valid", 32'(m_valid_o), 32'h0);
        chk("rst m_data",  32'(m_data_o),  32'h0);
        chk("rst m_qos",   32'(m_qos_o),   32'h0);
        chk("rst m_id",    32'(m_id_o),    32'h0);
        chk("rst m_last",  32'(m_last_o),  32'h0);

        @(negedge clk);
        nrst = 1'b1;
        #1;
        chk("release idle m_valid", 32'(m_valid_o), 32'h0);
        @(negedge clk);
        #1;
        chk("first grant m_valid", 32'(m_valid_o), 32'h1);
        chk("first grant m_id",    32'(m_id_o),    32'h1);
        #2;
        nrst = 1'b0;
        #1;
        chk("async rst m_valid", 32'(m_valid_o), 32'h0);
        chk("async rst m_id",    32'(m_id_o),    32'h0);
        s_valid_i = 4'h0;
        @(negedge clk);
        nrst = 1'b1;

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            s_valid_i = tbl[i].v;
            s_qos_i   = tbl[i].q;
            s_last_i  = tbl[i].l;
            m_ready_i = tbl[i].r;
            s_data_i  = DATA_TAB;
            #1;
            chk($sformatf("vec%0d m_valid", i), 32'(m_valid_o), 32'(tbl[i].ev));
            chk($sformatf("vec%0d m_id", i),    32'(m_id_o),    32'(tbl[i].id));
            chk($sformatf("vec%0d m_qos", i),   32'(m_qos_o),   32'(tbl[i].qos));
            chk($sformatf("vec%0d s_ready", i), 32'(s_ready_o), 32'(tbl[i].sr));
            chk($sformatf("vec%0d m_last", i),  32'(m_last_o),  32'(tbl[i].el));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d m_data", i), 32'(m_data_o), 32'(tbl[i].ed));
            end
        end

        // Backpressure: 4-beat S1 packet, ready toggling, higher-QoS S3 arriving mid-packet
        @(negedge clk);
        s_valid_i = 4'b0010;
        s_qos_i   = 16'h0010;
        s_last_i  = 4'h0;
        s_data_i  = 32'h0000_0100;
        m_ready_i = 1'b1;
        #1;
        chk("bp idle m_valid", 32'(m_valid_o), 32'h0);
        b = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            s_valid_i = 4'b1010;
            s_qos_i   = 16'hF010;
            s_data_i  = {16'h0, 8'(b + 1), 8'h0};
            s_last_i  = {1'b1, 1'b0, (b == 3), 1'b0};
            m_ready_i = (cyc % 2 == 0);
            #1;
            chk($sformatf("bp c%0d m_valid", cyc), 32'(m_valid_o), 32'h1);
            chk($sformatf("bp c%0d m_id", cyc),    32'(m_id_o),    32'h1);
            chk($sformatf("bp c%0d m_qos", cyc),   32'(m_qos_o),   32'h1);
            chk($sformatf("bp c%0d m_data", cyc),  32'(m_data_o),  32'(b + 1));
            chk($sformatf("bp c%0d m_last", cyc),  32'(m_last_o),  32'(b == 3));
            chk($sformatf("bp c%0d s_ready", cyc), 32'(s_ready_o), m_ready_i ? 32'h2 : 32'h0);
            if (m_ready_i) begin
                b++;
            end
            if (b == 4) begin
                break;
            end
        end
        chk("bp beats accepted", 32'(b), 32'd4);
        @(negedge clk);
        m_ready_i = 1'b1;
        #1;
        chk("bp bubble m_valid", 32'(m_valid_o), 32'h0);
        @(negedge clk);
        #1;
        chk("bp next m_id",    32'(m_id_o),    32'h3);
        chk("bp next m_qos",   32'(m_qos_o),   32'hF);
        chk("bp next s_ready", 32'(s_ready_o), 32'h8);

        // Reset during beat 2 of an S0 packet
        @(negedge clk);
        s_valid_i = 4'b0001;
        s_qos_i   = 16'h0007;
        s_last_i  = 4'h0;
        s_data_i  = 32'h0000_0001;
        #1;
        chk("mr idle m_valid", 32'(m_valid_o), 32'h0);
        @(negedge clk);
        #1;
        chk("mr beat1 m_valid", 32'(m_valid_o), 32'h1);
        chk("mr beat1 m_id",    32'(m_id_o),    32'h0);
        chk("mr beat1 m_data",  32'(m_data_o),  32'h1);
        @(negedge clk);
        s_data_i = 32'h0000_0002;
        #1;
        chk("mr beat2 m_data", 32'(m_data_o), 32'h2);
        #1;
        nrst = 1'b0;
        #1;
        chk("mr rst m_valid", 32'(m_valid_o), 32'h0);
        chk("mr rst s_ready", 32'(s_ready_o), 32'h0);
        chk("mr rst m_qos",   32'(m_qos_o),   32'h0);
        chk("mr rst m_id",    32'(m_id_o),    32'h0);
        s_valid_i = 4'hF;
        s_qos_i   = 16'h5555;
        s_last_i  = 4'hF;
        s_data_i  = DATA_TAB;
        @(negedge clk);
        nrst = 1'b1;
        #1;
        chk("mr release m_valid", 32'(m_valid_o), 32'h0);
        @(negedge clk);
        #1;
        chk("mr fresh m_valid", 32'(m_valid_o), 32'h1);
        chk("mr fresh m_id",    32'(m_id_o),    32'h1);

        // S0 qos=15 always vs S1 qos=0: aging build lets S1 through every 4th arbitration
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            s_valid_i = 4'b0011;
            s_qos_i   = 16'h000F;
            s_last_i  = 4'hF;
            m_ready_i = 1'b1;
            #1;
            chk($sformatf("age%0d bubble", k), 32'(m_valid_o), 32'h0);
            @(negedge clk);
            #1;
`ifdef QOS_AGING_EN
            exp_id = ((k == 3) || (k == 7)) ? 2'd1 : 2'd0;
`else
            exp_id = 2'd0;
`endif
            chk($sformatf("age%0d m_id", k),  32'(m_id_o),  32'(exp_id));
            chk($sformatf("age%0d m_qos", k), 32'(m_qos_o), (exp_id == 2'd1) ? 32'h0 : 32'hF);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
